// File: rtl/btn_load_capture.sv
// rtl/btn_load_capture.sv - load button debounce and switch capture into a one-entry holding buffer
module btn_load_capture #(
    parameter int DEBOUNCE_COUNT = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw,
    input  logic       take,
    output logic       load_valid,
    output logic [3:0] load_data,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic             btn_m;
    logic             btn_s;
    logic [3:0]       sw_m;
    logic [3:0]       sw_s;
    logic [CNT_W-1:0] cnt;

    logic pressed_s;
    logic differ;
    logic flip;
    logic rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b1;
            btn_s <= 1'b1;
            sw_m  <= 4'h0;
            sw_s  <= 4'h0;
        end else begin
            btn_m <= btn_n;
            btn_s <= btn_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
        end
    end

    assign pressed_s = ~btn_s;
    assign differ    = (pressed_s != btn_level);
    assign flip      = differ && (cnt == CNT_LAST);
    assign rise      = flip && pressed_s;

    // Any cycle of agreement restarts the count, so bounces never accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (flip) begin
            cnt       <= '0;
            btn_level <= pressed_s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A capture wins over a same-cycle take; overrun only when an unconsumed value is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_valid  <= 1'b0;
            load_data   <= 4'h0;
            press_pulse <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            press_pulse <= rise;
            overrun     <= rise && load_valid && !take;
            if (rise) begin
                load_valid <= 1'b1;
                load_data  <= sw_s;
            end else if (take && load_valid) begin
                load_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_load_capture.sv
// tb/tb_btn_load_capture.sv - self-checking bench for btn_load_capture
module tb_btn_load_capture;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic [3:0] sw = 4'hA;
    logic       take = 1'b0;
    logic       load_valid;
    logic [3:0] load_data;
    logic       btn_level;
    logic       press_pulse;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    btn_load_capture #(.DEBOUNCE_COUNT(N), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .sw(sw), .take(take),
        .load_valid(load_valid), .load_data(load_data), .btn_level(btn_level),
        .press_pulse(press_pulse), .overrun(overrun)
    );

    always #10 clk = ~clk;

    // Reference: level flips once the current and previous N-1 pressed samples all disagree with it
    logic       m_b1, m_b2;
    logic [3:0] m_s1, m_s2;
    logic       hist [N-1];
    logic       m_level, m_pulse, m_valid, m_ovr;
    logic [3:0] m_data;
    logic       p, fl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_b1 <= 1'b1; m_b2 <= 1'b1; m_s1 <= 4'h0; m_s2 <= 4'h0;
            for (int i = 0; i < N-1; i++) hist[i] <= 1'b0;
            m_level <= 1'b0; m_pulse <= 1'b0; m_valid <= 1'b0; m_ovr <= 1'b0; m_data <= 4'h0;
        end else begin
            p  = ~m_b2;
            fl = (p != m_level);
            for (int i = 0; i < N-1; i++) if (hist[i] == m_level) fl = 1'b0;
            hist[0] <= p;
            for (int i = 1; i < N-1; i++) hist[i] <= hist[i-1];
            m_b1 <= btn_n; m_b2 <= m_b1; m_s1 <= sw; m_s2 <= m_s1;
            if (fl) m_level <= p;
            m_pulse <= fl && p;
            m_ovr   <= fl && p && m_valid && !take;
            if (fl && p) begin
                m_valid <= 1'b1;
                m_data  <= m_s2;
            end else if (take) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model", {load_valid, load_data, btn_level, press_pulse, overrun},
            {m_valid, m_data, m_level, m_pulse, m_ovr});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_capture(input logic [3:0] v);
        sw = v; btn_n = 1'b0; cyc(10);
        btn_n = 1'b1; cyc(10);
    endtask

    typedef struct {
        logic       b;
        logic [3:0] s;
        logic       t;
        int         hold;
        logic       e_level;
        logic       e_valid;
        logic [3:0] e_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 4'hA, 1'b0, 10, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 4'h7, 1'b0, 5,  1'b0, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 4'h7, 1'b0, 1,  1'b1, 1'b1, 4'h7};
        tbl[3] = '{1'b0, 4'hE, 1'b0, 5,  1'b1, 1'b1, 4'h7};
        tbl[4] = '{1'b1, 4'hE, 1'b0, 5,  1'b1, 1'b1, 4'h7};
        tbl[5] = '{1'b1, 4'hE, 1'b0, 1,  1'b0, 1'b1, 4'h7};
        tbl[6] = '{1'b1, 4'hE, 1'b1, 1,  1'b0, 1'b0, 4'h7};
        tbl[7] = '{1'b1, 4'hE, 1'b1, 1,  1'b0, 1'b0, 4'h7};
        tbl[8] = '{1'b0, 4'h4, 1'b0, 2,  1'b0, 1'b0, 4'h7};
        tbl[9] = '{1'b1, 4'h4, 1'b0, 8,  1'b0, 1'b0, 4'h7};

        // Reset with clock running
        cyc(3);
        chk("reset_out", {load_valid, load_data, btn_level, press_pulse, overrun}, 8'h0);
        rst = 1'b0;
        cyc(10);
        chk("post_reset_out", {load_valid, load_data, btn_level, press_pulse, overrun}, 8'h0);

        for (int i = 0; i < 10; i++) begin
            btn_n = tbl[i].b; sw = tbl[i].s; take = tbl[i].t;
            cyc(tbl[i].hold);
            chk($sformatf("tbl%0d", i), {tbl[i].e_level, tbl[i].e_valid, tbl[i].e_data},
                {btn_level, load_valid, load_data});
        end
        take = 1'b0;

        // Bounce from a clean state
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);
        for (int k = 0; k < 16; k++) begin
            btn_n = k[1]; cyc(1);
            chk("bounce", {btn_level, press_pulse, load_valid}, 3'b000);
        end
        btn_n = 1'b1; cyc(8);

        // Clean press: exact edge of rise and single pulse
        sw = 4'h5; btn_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk($sformatf("press_lvl_e%0d", k), btn_level, (k >= 6));
            chk($sformatf("press_pls_e%0d", k), press_pulse, (k == 6));
        end
        chk("press_data", {load_valid, load_data}, {1'b1, 4'h5});
        btn_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("rel_lvl_e%0d", k), btn_level, (k < 6));
            chk("rel_no_pulse", press_pulse, 1'b0);
        end

        // Handshake
        take = 1'b1; cyc(1); take = 1'b0;
        press_capture(4'h3);
        take = 1'b1; cyc(1);
        chk("take1", {load_valid, load_data}, {1'b0, 4'h3});
        cyc(1); take = 1'b0;
        chk("take2", {load_valid, load_data}, {1'b0, 4'h3});

        // Overrun
        press_capture(4'h1);
        sw = 4'h9; btn_n = 1'b0; cyc(6);
        chk("ovr_hit", {overrun, press_pulse, load_valid, load_data}, {3'b111, 4'h9});
        cyc(1);
        chk("ovr_once", {overrun, press_pulse}, 2'b00);
        btn_n = 1'b1; cyc(10);

        // Collision: capture lands on the same edge as take
        take = 1'b1; cyc(1); take = 1'b0;
        press_capture(4'h2);
        sw = 4'hC; btn_n = 1'b0; cyc(5);
        take = 1'b1; cyc(1); take = 1'b0;
        chk("collide", {overrun, press_pulse, load_valid, load_data}, {3'b011, 4'hC});
        btn_n = 1'b1; cyc(10);

        // Reset mid-debounce with button held through release
        take = 1'b1; cyc(1); take = 1'b0;
        sw = 4'h6; btn_n = 1'b0; cyc(4);
        rst = 1'b1; #1;
        chk("async_rst", {load_valid, load_data, btn_level, press_pulse, overrun}, 8'h0);
        cyc(2); rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("held_rst_e%0d", k), press_pulse, (k == 6));
        end
        chk("held_rst_data", {load_valid, load_data}, {1'b1, 4'h6});
        btn_n = 1'b1; cyc(10);

        // Random phase against the reference model
        for (int r = 0; r < 120; r++) begin
            btn_n = $urandom_range(1);
            sw = 4'($urandom);
            for (int h = $urandom_range(8, 1); h > 0; h--) begin
                take = ($urandom_range(4) == 0);
                cyc(1);
            end
        end
        take = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
